dmem_master: RTL

- Initiator side of the data-memory port; the micro-sequencer issues load/store/fill/block-read commands to it.
- Drives cs/we/Outenab/Address/data_in, samples Dio, and returns read words with a valid strobe.
- Sequences bursts of 1–16 consecutive words so the control unit issues one command per transfer, not one per word.

---
 rtl/dmem_master.sv | 99 +++++++++
 1 files changed

// File: rtl/dmem_master.sv
// Data-memory initiator: turns one load/store/fill/block-read command into a
// burst of 1..16 single-cycle memory accesses and returns read words with a strobe.
module dmem_master #(
    parameter int AW = 8,
    parameter int DW = 16,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic [AW-1:0] raddr,
    output logic          cs,
    output logic          we,
    output logic          Outenab,
    output logic [AW-1:0] Address,
    output logic [DW-1:0] data_in,
    input  logic [DW-1:0] Dio
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cur_addr, addr_nxt;
    logic [LW-1:0] count, count_nxt;
    logic [LW-1:0] len_q, len_nxt;
    logic [DW-1:0] wdata_q, wdata_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_addr <= '0;
            count    <= '0;
            len_q    <= '0;
            wdata_q  <= '0;
            rdata    <= '0;
            raddr    <= '0;
            rvalid   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cur_addr <= addr_nxt;
            count    <= count_nxt;
            len_q    <= len_nxt;
            wdata_q  <= wdata_nxt;
            rvalid   <= (state == RD);
            // Dio is valid combinationally during RD, so capture it at the closing edge
            if (state == RD) begin
                rdata <= Dio;
                raddr <= cur_addr;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = cur_addr;
        count_nxt = count;
        len_nxt   = len_q;
        wdata_nxt = wdata_q;
        case (state)
            IDLE: begin
                if (start) begin
                    addr_nxt  = addr;
                    len_nxt   = len;
                    wdata_nxt = wdata;
                    count_nxt = '0;
                    state_nxt = wr ? WR : RD;
                end
            end
            RD, WR: begin
                if (count == len_q) begin
                    state_nxt = DONE;
                end else begin
                    addr_nxt  = cur_addr + AW'(1);
                    count_nxt = count + LW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes decode straight from the state register, so reset clears them at once
    assign cs      = (state == RD) || (state == WR);
    assign we      = (state == WR);
    assign Outenab = (state == RD);
    assign busy    = cs;
    assign done    = (state == DONE);
    assign Address = cur_addr;
    assign data_in = wdata_q;

endmodule
